// File: rtl/fpu_seq_multiplier_pkg.sv
// Shared types for the sequential shift-add mantissa multiplier.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpu_seq_multiplier_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_COMP = 2'd1,
      MUL_DONE = 2'd2
   } fpuMulState_t;

   // Iteration counter width for a given operand width (must hold WIDTH itself).
   function automatic int mul_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/fpu_seq_multiplier_fsm.sv
// Control FSM for the sequential multiplier: idle / computing / done.
// Latency: one state transition per clock; accept on start in IDLE or DONE.
// Backpressure: start is ignored while computing (busy high).
module fpu_seq_multiplier_fsm
   import fpu_seq_multiplier_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic compDone,
   output logic compEn,
   output logic loadEn,
   output logic busy,
   output logic done
);

   fpuMulState_t state_q, state_d;

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MUL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode; done is a level held in MUL_DONE.
   always_comb begin
      state_d = state_q;
      compEn  = 1'b0;
      loadEn  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               loadEn  = 1'b1;
               state_d = MUL_COMP;
            end
         end
         MUL_COMP: begin
            busy   = 1'b1;
            compEn = 1'b1;
            if (compDone) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: begin
            done = 1'b1;
            if (start) begin
               loadEn  = 1'b1;
               state_d = MUL_COMP;
            end
         end
         default: begin
            state_d = MUL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/fpu_seq_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per clock.
// Latency: WIDTH clocks from the accepting edge to done and the new mulOut.
// Backpressure: start is only honoured when not busy; mulOut holds until next completion.
module fpu_seq_multiplier
   import fpu_seq_multiplier_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mulIn1,
   input  logic [WIDTH-1:0]     mulIn2,
   output logic [2*WIDTH-1:0]   mulOut,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = mul_cnt_width(WIDTH);

   logic               compEn;
   logic               loadEn;
   logic               compDone;

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mulOut_q, mulOut_d;

   logic [WIDTH:0]     addend;
   logic [WIDTH:0]     sum;

   assign compDone = (cnt_q == CW'(1));
   assign mulOut   = mulOut_q;

   fpu_seq_multiplier_fsm u_fsm (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .compDone (compDone),
      .compEn   (compEn),
      .loadEn   (loadEn),
      .busy     (busy),
      .done     (done)
   );

   // One shift-add step: conditionally add the multiplicand, then shift {acc,q} right,
   // dropping the carry into the product MSB. acc[WIDTH] is always 0 between steps,
   // so adding the full acc equals adding its low WIDTH bits.
   always_comb begin
      addend   = q_q[0] ? {1'b0, mcand_q} : '0;
      sum      = acc_q + addend;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      mulOut_d = mulOut_q;
      if (loadEn) begin
         mcand_d = mulIn1;
         acc_d   = '0;
         q_d     = mulIn2;
         cnt_d   = CW'(WIDTH);
      end else if (compEn) begin
         acc_d = {1'b0, sum[WIDTH:1]};
         q_d   = {sum[0], q_q[WIDTH-1:1]};
         cnt_d = cnt_q - CW'(1);
         if (compDone) begin
            mulOut_d = {acc_d[WIDTH-1:0], q_d};
         end
      end
   end

   // Datapath registers; reset clears operands, working register, counter and result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         mulOut_q <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         mulOut_q <= mulOut_d;
      end
   end

endmodule

// File: tb/tb_fpu_seq_multiplier.sv
// Self-checking bench: directed vector table, random products, ignored start, async reset.
// Latency: expects done exactly WIDTH clocks after the accepting edge.
// Backpressure: drives start during busy and checks it is ignored.
module tb_fpu_seq_multiplier;

   localparam int W = 16;

   logic            clock;
   logic            reset_n;
   logic            start;
   logic [W-1:0]    mulIn1;
   logic [W-1:0]    mulIn2;
   logic [2*W-1:0]  mulOut;
   logic            busy;
   logic            done;

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] last_res = '0;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
      int             ign;   // busy cycle at which a stray start is pulsed (-1: none)
      string          nm;
   } vec_t;

   vec_t vecs[8];

   fpu_seq_multiplier #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .mulIn1  (mulIn1),
      .mulIn2  (mulIn2),
      .mulOut  (mulOut),
      .busy    (busy),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Caller sits #1 after a rising edge. Drives a start, counts busy cycles,
   // scrambles the inputs meanwhile and optionally pulses a stray start.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int ign, input string nm);
      int cnt = 0;
      bit stable = 1'b1;
      logic [2*W-1:0] prev = last_res;
      start  = 1'b1;
      mulIn1 = a;
      mulIn2 = b;
      @(posedge clock); #1;
      start = 1'b0;
      chk({nm, "_done_low_after_accept"}, 64'(done), 64'd0);
      while (busy && cnt < 40) begin
         cnt++;
         if (mulOut !== prev) stable = 1'b0;
         mulIn1 = W'($urandom);
         mulIn2 = W'($urandom);
         start  = (cnt == ign);
         @(posedge clock); #1;
      end
      start = 1'b0;
      chk({nm, "_busy_cycles"}, 64'(cnt), 64'(W));
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_mulOut"}, 64'(mulOut), 64'(exp));
      chk({nm, "_mulOut_held"}, 64'(stable), 64'd1);
      last_res = exp;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [2*W-1:0] rexp;
      bit saw_done;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, -1, "3x5"};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1, "max_x_max"};
      vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, -1, "x_times_0"};
      vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000, -1, "0_times_x"};
      vecs[4] = '{16'h00FF, 16'h0100, 32'h0000FF00,  5, "start_while_busy"};
      vecs[5] = '{16'h0003, 16'h0005, 32'h0000000F, -1, "3x5_again"};
      vecs[6] = '{16'h8000, 16'h0002, 32'h00010000, -1, "restart_from_done"};
      vecs[7] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, -1, "max_x_1"};

      reset_n = 1'b0;
      start   = 1'b0;
      mulIn1  = '0;
      mulIn2  = '0;
      #12;
      chk("reset_mulOut", 64'(mulOut), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("idle_no_done", 64'(done), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].ign, vecs[i].nm);
      end

      for (int i = 0; i < 25; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         if (i == 0) ra = '1;
         rexp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
         run_op(ra, rb, rexp, (i % 3 == 0) ? 3 + i % 7 : -1, "rand");
      end

      // Asynchronous reset seven cycles into an operation.
      start  = 1'b1;
      mulIn1 = 16'h1111;
      mulIn2 = 16'h2222;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (6) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      chk("async_rst_mulOut", 64'(mulOut), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      saw_done = 1'b0;
      repeat (24) begin
         @(posedge clock); #1;
         if (done || busy) saw_done = 1'b1;
      end
      chk("after_rst_idle_quiet", 64'(saw_done), 64'd0);
      last_res = '0;
      run_op(16'h0007, 16'h0007, 32'h00000031, -1, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
